// File: rtl/nonce_sweep_ctrl_if.sv
// Core-side bus between the nonce sweep controller and one hash core.
// Latency: wires only, no storage.
// Backpressure: none; the core reports completion with a single-cycle done strobe.
interface nonce_sweep_ctrl_if #(
    parameter int NONCE_W = 32
);
    logic                     core_n_rst;
    logic                     core_enable;
    logic [608+NONCE_W-1:0]   core_data;
    logic [255:0]             core_hash;
    logic                     core_hash_done;

    // Controller side drives reset/enable/data and receives the hash.
    modport master (
        output core_n_rst,
        output core_enable,
        output core_data,
        input  core_hash,
        input  core_hash_done
    );

    // Hash core side.
    modport slave (
        input  core_n_rst,
        input  core_enable,
        input  core_data,
        output core_hash,
        output core_hash_done
    );
endinterface

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps nonces start..end (inclusive, wrapping) through one hash core and flags the first hash <= target.
// Latency: per nonce 1 core-reset + 1 kick + core latency + 1 check cycle; found/exhausted 1 cycle after check.
// Backpressure: none; start is ignored while busy, abort cancels at any busy cycle.
// Optional: define NONCE_SWEEP_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES and report timeout_err.
module nonce_sweep_ctrl #(
    parameter int NONCE_W        = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [607:0]         header,
    input  logic [NONCE_W-1:0]   start_nonce,
    input  logic [NONCE_W-1:0]   end_nonce,
    input  logic [255:0]         target,
    nonce_sweep_ctrl_if.master   core,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic                 timeout_err,
    output logic [NONCE_W-1:0]   found_nonce,
    output logic [255:0]         found_hash,
    output logic [31:0]          hash_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_KICK,
        S_WAIT,
        S_CHECK,
        S_FOUND,
        S_EXHAUST
    } state_t;

    state_t               state;
    logic [607:0]         header_q;
    logic [NONCE_W-1:0]   end_q;
    logic [255:0]         target_q;
    logic [NONCE_W-1:0]   cur_nonce;
    logic [255:0]         hash_q;
    logic                 to_idle;      // current CRST is a cancel/timeout reset, return to IDLE after it
    logic                 rst_hold;     // stretches core reset one cycle past rst release
    logic                 core_n_rst_q;
    logic                 core_enable_q;
    logic [NONCE_W-1:0]   nonce_le;
    logic [255:0]         hash_val;
    logic                 hit;

`ifdef NONCE_SWEEP_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]     wait_cnt;
    logic                 timeout_q;
    assign timeout_err = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign timeout_err = 1'b0;
`endif

    // Nonce goes to the core little-endian; the hash compares as a little-endian integer.
    always_comb begin
        nonce_le = '0;
        hash_val = '0;
        for (int i = 0; i < NONCE_W / 8; i++) begin
            nonce_le[8*i +: 8] = cur_nonce[NONCE_W-8-8*i +: 8];
        end
        for (int i = 0; i < 32; i++) begin
            hash_val[8*i +: 8] = hash_q[255-8*i -: 8];
        end
    end

    assign hit              = (hash_val <= target_q);
    assign busy             = (state != S_IDLE);
    assign core.core_data   = {header_q, nonce_le};
    assign core.core_n_rst  = core_n_rst_q;
    assign core.core_enable = core_enable_q;

    // Sweep state machine with registered core controls and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            header_q      <= '0;
            end_q         <= '0;
            target_q      <= '0;
            cur_nonce     <= '0;
            hash_q        <= '0;
            to_idle       <= 1'b0;
            rst_hold      <= 1'b1;
            core_n_rst_q  <= 1'b0;
            core_enable_q <= 1'b0;
            found         <= 1'b0;
            exhausted     <= 1'b0;
            found_nonce   <= '0;
            found_hash    <= '0;
            hash_count    <= '0;
`ifdef NONCE_SWEEP_TIMEOUT_EN
            wait_cnt      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            core_n_rst_q  <= !rst_hold;
            rst_hold      <= 1'b0;
            core_enable_q <= 1'b0;
            if (state != S_IDLE && abort) begin
                // Cancel: one core reset cycle, then idle; a cancel during CRST already has its reset cycle.
                found     <= 1'b0;
                exhausted <= 1'b0;
                if (state == S_CRST) begin
                    state <= S_IDLE;
                end else begin
                    state        <= S_CRST;
                    to_idle      <= 1'b1;
                    core_n_rst_q <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            header_q     <= header;
                            end_q        <= end_nonce;
                            target_q     <= target;
                            cur_nonce    <= start_nonce;
                            found        <= 1'b0;
                            exhausted    <= 1'b0;
                            hash_count   <= '0;
                            to_idle      <= 1'b0;
                            core_n_rst_q <= 1'b0;
                            state        <= S_CRST;
`ifdef NONCE_SWEEP_TIMEOUT_EN
                            timeout_q    <= 1'b0;
`endif
                        end
                    end
                    S_CRST: begin
                        if (to_idle) begin
                            state <= S_IDLE;
                        end else begin
                            core_enable_q <= 1'b1;
                            state         <= S_KICK;
                        end
                    end
                    S_KICK: begin
                        state <= S_WAIT;
`ifdef NONCE_SWEEP_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (core.core_hash_done) begin
                            hash_q <= core.core_hash;
                            if (hash_count != 32'hFFFF_FFFF) begin
                                hash_count <= hash_count + 32'd1;
                            end
                            state <= S_CHECK;
                        end
`ifdef NONCE_SWEEP_TIMEOUT_EN
                        else if (wait_cnt == WAIT_LAST) begin
                            timeout_q    <= 1'b1;
                            to_idle      <= 1'b1;
                            core_n_rst_q <= 1'b0;
                            state        <= S_CRST;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
`endif
                    end
                    S_CHECK: begin
                        if (hit) begin
                            found_nonce <= cur_nonce;
                            found_hash  <= hash_q;
                            found       <= 1'b1;
                            state       <= S_FOUND;
                        end else if (cur_nonce == end_q) begin
                            exhausted <= 1'b1;
                            state     <= S_EXHAUST;
                        end else begin
                            cur_nonce    <= cur_nonce + NONCE_W'(1);
                            core_n_rst_q <= 1'b0;
                            state        <= S_CRST;
                        end
                    end
                    S_FOUND:   state <= S_IDLE;
                    S_EXHAUST: state <= S_IDLE;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: table of sweep jobs plus hand sequences for reset, abort, busy-start and timeout.
// Latency: core model answers 5 cycles after core_enable.
// Backpressure: none; every wait on the DUT is cycle-bounded.
module tb_nonce_sweep_ctrl;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [607:0]   header;
    logic [31:0]    start_nonce;
    logic [31:0]    end_nonce;
    logic [255:0]   target;
    logic           busy;
    logic           found;
    logic           exhausted;
    logic           timeout_err;
    logic [31:0]    found_nonce;
    logic [255:0]   found_hash;
    logic [31:0]    hash_count;

    always #5 clk = ~clk;

    nonce_sweep_ctrl_if #(.NONCE_W(32)) core_if ();

    nonce_sweep_ctrl #(.NONCE_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .header      (header),
        .start_nonce (start_nonce),
        .end_nonce   (end_nonce),
        .target      (target),
        .core        (core_if),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .timeout_err (timeout_err),
        .found_nonce (found_nonce),
        .found_hash  (found_hash),
        .hash_count  (hash_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Core model: 5-cycle latency, returns hit_hash for hit_nonce and all-ones otherwise.
    logic [255:0] hit_hash;
    logic [31:0]  hit_nonce;
    logic         mute;
    int           lat = 0;
    logic [31:0]  issued[$];

    always @(posedge clk) begin
        if (!core_if.core_n_rst) begin
            lat <= 0;
            core_if.core_hash_done <= 1'b0;
        end else begin
            core_if.core_hash_done <= 1'b0;
            if (core_if.core_enable) begin
                lat <= 4;
                issued.push_back(bswap32(core_if.core_data[31:0]));
                core_if.core_hash <= (bswap32(core_if.core_data[31:0]) == hit_nonce) ? hit_hash : '1;
            end else if (lat > 0) begin
                lat <= lat - 1;
                if (lat == 1 && !mute) core_if.core_hash_done <= 1'b1;
            end
        end
    end

    typedef struct {
        logic [31:0]  sn;
        logic [31:0]  en;
        logic [31:0]  hn;
        logic [255:0] hh;
        logic [255:0] tgt;
        logic         ef;
        logic         ee;
        logic [31:0]  efn;
        logic [31:0]  ecnt;
        logic [31:0]  first;
        logic [31:0]  last;
    } vec_t;

    task automatic start_job(input logic [31:0] sn, input logic [31:0] en, input logic [31:0] hn,
                             input logic [255:0] hh, input logic [255:0] tgt);
        @(posedge clk); #1;
        start_nonce = sn;
        end_nonce   = en;
        target      = tgt;
        hit_nonce   = hn;
        hit_hash    = hh;
        issued.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle_in_time"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[6];
        logic [255:0] hash_hit;
        logic [255:0] tgt_hit;
        logic [255:0] hash_b;
        logic [255:0] tgt_b;
        logic [255:0] tgt_b_m1;
        logic [607:0] hdr;
        logic [31:0]  first_i;
        logic [31:0]  last_i;
        int           n;

        hash_hit = 256'h01796dae_11223344_55667788_99aabbcc_ddeeff00_12345678_2aa54b3b_00000000;
        tgt_hit  = 256'hFFFF << 208;
        hash_b   = 256'h00112233_44556677_8899aabb_ccddeeff_00010203_04050607_08090a0b_0c0d0e0f;
        tgt_b    = 256'h0f0e0d0c_0b0a0908_07060504_03020100_ffeeddcc_bbaa9988_77665544_33221100;
        tgt_b_m1 = 256'h0f0e0d0c_0b0a0908_07060504_03020100_ffeeddcc_bbaa9988_77665544_332210ff;
        hdr      = {32'h00000002, {18{32'h5a5ac3c3}}};

        //           sn            en            hn            hh        tgt       ef    ee    efn           ecnt   first         last
        vecs[0] = '{32'h80019245, 32'h80019245, 32'h80019245, hash_hit, tgt_hit,  1'b1, 1'b0, 32'h80019245, 32'd1, 32'h80019245, 32'h80019245};
        vecs[1] = '{32'hFFFFFFFE, 32'h00000001, 32'h12345678, hash_b,   tgt_hit,  1'b0, 1'b1, 32'h0,        32'd4, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'h00000005, 32'h00000005, 32'h00000005, hash_b,   tgt_b,    1'b1, 1'b0, 32'h00000005, 32'd1, 32'h00000005, 32'h00000005};
        vecs[3] = '{32'h00000005, 32'h00000005, 32'h00000005, hash_b,   tgt_b_m1, 1'b0, 1'b1, 32'h0,        32'd1, 32'h00000005, 32'h00000005};
        vecs[4] = '{32'h0000000A, 32'h00000014, 32'h0000000D, hash_b,   tgt_b,    1'b1, 1'b0, 32'h0000000D, 32'd4, 32'h0000000A, 32'h0000000D};
        vecs[5] = '{32'hFFFFFFFF, 32'h00000002, 32'h00000001, hash_b,   tgt_b,    1'b1, 1'b0, 32'h00000001, 32'd3, 32'hFFFFFFFF, 32'h00000001};

        rst = 1'b1; start = 1'b0; abort = 1'b0; header = hdr;
        start_nonce = '0; end_nonce = '0; target = '0;
        mute = 1'b0; hit_nonce = '0; hit_hash = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",        busy,                 0);
        chk("rst_found",       found,                0);
        chk("rst_exhausted",   exhausted,            0);
        chk("rst_timeout",     timeout_err,          0);
        chk("rst_hash_count",  hash_count,           0);
        chk("rst_found_nonce", found_nonce,          0);
        chk("rst_found_hash",  found_hash,           0);
        chk("rst_core_n_rst",  core_if.core_n_rst,   0);
        chk("rst_core_enable", core_if.core_enable,  0);
        chk("rst_core_data",   core_if.core_data,    0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_tail_low",    core_if.core_n_rst,   0);
        @(posedge clk); #1;
        chk("rst_released",    core_if.core_n_rst,   1);

        // Table of sweep jobs.
        for (int i = 0; i < 6; i++) begin
            start_job(vecs[i].sn, vecs[i].en, vecs[i].hn, vecs[i].hh, vecs[i].tgt);
            wait_idle($sformatf("v%0d", i), 400);
            first_i = (issued.size() > 0) ? issued[0] : 32'hDEADBEEF;
            last_i  = (issued.size() > 0) ? issued[issued.size()-1] : 32'hDEADBEEF;
            chk($sformatf("v%0d_found", i),       found,                 vecs[i].ef);
            chk($sformatf("v%0d_exhausted", i),   exhausted,             vecs[i].ee);
            chk($sformatf("v%0d_hash_count", i),  hash_count,            vecs[i].ecnt);
            chk($sformatf("v%0d_issued_cnt", i),  32'(issued.size()),    vecs[i].ecnt);
            chk($sformatf("v%0d_first_nonce", i), first_i,               vecs[i].first);
            chk($sformatf("v%0d_last_nonce", i),  last_i,                vecs[i].last);
            chk($sformatf("v%0d_timeout", i),     timeout_err,           0);
            if (vecs[i].ef) begin
                chk($sformatf("v%0d_found_nonce", i), found_nonce, vecs[i].efn);
                chk($sformatf("v%0d_found_hash", i),  found_hash,  vecs[i].hh);
            end
            if (i == 0) begin
                chk("v0_core_data_nonce",  core_if.core_data[31:0],   32'h45920180);
                chk("v0_core_data_header", core_if.core_data[639:32], hdr);
            end
        end

        // Start while busy must not disturb the running job.
        start_job(32'h0, 32'h2, 32'h100, hash_b, tgt_b);
        repeat (3) @(posedge clk);
        #1;
        start_nonce = 32'h50; end_nonce = 32'h50; target = '1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("busy_start", 400);
        chk("busy_start_exhausted", exhausted,          1);
        chk("busy_start_count",     hash_count,         3);
        chk("busy_start_issued",    32'(issued.size()), 3);

        // Abort on the same cycle as core_hash_done.
        start_job(32'h0, 32'd100, 32'h1000, hash_b, tgt_b);
        n = 0;
        while (hash_count != 32'd1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_first_hash", hash_count, 1);
        n = 0;
        while (!core_if.core_hash_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_done_seen", core_if.core_hash_done, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_core_rst_low", core_if.core_n_rst, 0);
        chk("abort_busy_in_crst", busy,               1);
        chk("abort_count_kept",   hash_count,         1);
        @(posedge clk); #1;
        chk("abort_idle",         busy,               0);
        chk("abort_core_rst_hi",  core_if.core_n_rst, 1);
        chk("abort_found",        found,              0);
        chk("abort_exhausted",    exhausted,          0);
        chk("abort_count_final",  hash_count,         1);
        start_job(32'h7, 32'h7, 32'h7, hash_b, tgt_b);
        wait_idle("post_abort", 200);
        chk("post_abort_found",   found,       1);
        chk("post_abort_nonce",   found_nonce, 32'h7);

        // Reset in the middle of WAIT clears everything and beats start/abort.
        start_job(32'h0, 32'd100, 32'h1000, hash_b, tgt_b);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy",        busy,                0);
        chk("midrst_found",       found,               0);
        chk("midrst_found_nonce", found_nonce,         0);
        chk("midrst_count",       hash_count,          0);
        chk("midrst_core_n_rst",  core_if.core_n_rst,  0);
        chk("midrst_core_data",   core_if.core_data,   0);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_stay_idle",   busy,                0);

        // WAIT with a silent core.
        mute = 1'b1;
        start_job(32'h0, 32'h5, 32'h1000, hash_b, tgt_b);
`ifdef NONCE_SWEEP_TIMEOUT_EN
        repeat (17) @(posedge clk);
        #1;
        chk("to_still_waiting", busy,               1);
        chk("to_not_yet",       timeout_err,        0);
        @(posedge clk); #1;
        chk("to_flag",          timeout_err,        1);
        chk("to_core_rst",      core_if.core_n_rst, 0);
        @(posedge clk); #1;
        chk("to_idle",          busy,               0);
        chk("to_found",         found,              0);
        chk("to_exhausted",     exhausted,          0);
        chk("to_core_rst_hi",   core_if.core_n_rst, 1);
`else
        repeat (40) @(posedge clk);
        #1;
        chk("nto_still_waiting", busy,        1);
        chk("nto_flag",          timeout_err, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle("nto_abort", 10);
`endif
        mute = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
